// File: rtl/axi_wb_pkg.sv
// Shared definitions for the AXI4-Lite <-> Wishbone bridges.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Contents: AXI response codes, bridge state encoding, clog2 helper.
package axi_wb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB_WR  = 3'd1,
    WB_RD  = 3'd2,
    B_RESP = 3'd3,
    R_RESP = 3'd4
  } state_t;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(9) = 4.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_lite_to_wb_bridge_if.sv
// Bus bundles for the AXI4-Lite to Wishbone bridge.
// Latency: n/a (wiring only).
// Backpressure: AXI channels use valid/ready; Wishbone uses cyc/stb with ack/err.
//
// axi_lite_if: AXI4-Lite channels (AW, W, B, AR, R); master drives valids, slave drives readies.
// wb_if:       Wishbone classic bus; master drives cyc/stb/we/adr/dat_o/sel, slave drives dat_i/ack/err.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                      s_awvalid;
  logic [ADDR_WIDTH-1:0]     s_awaddr;
  logic                      s_awready;
  logic                      s_wvalid;
  logic [DATA_WIDTH-1:0]     s_wdata;
  logic [DATA_WIDTH/8-1:0]   s_wstrb;
  logic                      s_wready;
  logic                      s_bvalid;
  logic [1:0]                s_bresp;
  logic                      s_bready;
  logic                      s_arvalid;
  logic [ADDR_WIDTH-1:0]     s_araddr;
  logic                      s_arready;
  logic                      s_rvalid;
  logic [DATA_WIDTH-1:0]     s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rready;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready,
           s_rvalid, s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready,
           s_rvalid, s_rdata, s_rresp
  );
endinterface

interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                      wb_cyc_o;
  logic                      wb_stb_o;
  logic                      wb_we_o;
  logic [ADDR_WIDTH-1:0]     wb_adr_o;
  logic [DATA_WIDTH-1:0]     wb_dat_o;
  logic [DATA_WIDTH/8-1:0]   wb_sel_o;
  logic [DATA_WIDTH-1:0]     wb_dat_i;
  logic                      wb_ack_i;
  logic                      wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/bridge_timeout_ctr.sv
// Watchdog for a Wishbone cycle: flags the cycle in which the wait reaches TIMEOUT.
// Latency: expired is combinational on en and the registered count.
// Backpressure: none; en stalls the count, clr restarts it; TIMEOUT=0 never expires.
//
// Ports: wb_clk_i, wb_rst_i (async, active-high), clr (restart count),
//        en (cycle without ack/err), expired (this is the TIMEOUT-th such cycle).
module bridge_timeout_ctr
  import axi_wb_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + CW'(1);
        end
      end

      // The edge closing this cycle would bring the count to TIMEOUT, so the
      // owner can terminate on that same edge instead of one cycle later.
      assign expired = en && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/axi4_lite_to_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master; serialises reads and writes onto one WB cycle.
// Latency: zero-wait slave gives B/R valid 2 edges after the last AW/W (or AR) handshake.
// Backpressure: one holding register per AW/W/AR, ready = !full; B/R held until bready/rready.
//
// Ports: wb_clk_i, wb_rst_i (async, active-high); s_axi (axi_lite_if.slave);
//        wb (wb_if.master). Timeout of TIMEOUT WB cycles answers SLVERR (0 disables).
module axi4_lite_to_wb_bridge
  import axi_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  axi_lite_if.slave   s_axi,
  wb_if.master        wb
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_t                  state;
  logic                    last_wr;

  logic                    aw_full, w_full, ar_full;
  logic                    aw_full_nx, w_full_nx, ar_full_nx;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;

  logic                    awready_q, wready_q, arready_q;
  logic                    bvalid_q, rvalid_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    cyc_q, we_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_o_q;
  logic [STRB_W-1:0]       sel_q;

  logic aw_hs, w_hs, ar_hs;
  logic in_wb, tmo_expired, term, wr_term, rd_term;
  logic write_req, read_req;
  logic [1:0] term_resp;

  assign aw_hs = s_axi.s_awvalid & awready_q;
  assign w_hs  = s_axi.s_wvalid  & wready_q;
  assign ar_hs = s_axi.s_arvalid & arready_q;

  assign in_wb   = (state == WB_WR) || (state == WB_RD);
  assign term    = in_wb && (wb.wb_ack_i || wb.wb_err_i || tmo_expired);
  assign wr_term = term && (state == WB_WR);
  assign rd_term = term && (state == WB_RD);
  // Anything other than a clean ack (err, err+ack, timeout) is SLVERR.
  assign term_resp = (wb.wb_err_i || !wb.wb_ack_i) ? RESP_SLVERR : RESP_OKAY;

  assign write_req = aw_full & w_full;
  assign read_req  = ar_full;

  bridge_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (!in_wb),
    .en       (in_wb && !wb.wb_ack_i && !wb.wb_err_i),
    .expired  (tmo_expired)
  );

  // Full flags free up when the WB cycle ends, so the next request can be
  // captured while the response is still waiting on the master.
  always_comb begin
    aw_full_nx = aw_full;
    w_full_nx  = w_full;
    ar_full_nx = ar_full;
    if (aw_hs)        aw_full_nx = 1'b1;
    else if (wr_term) aw_full_nx = 1'b0;
    if (w_hs)         w_full_nx  = 1'b1;
    else if (wr_term) w_full_nx  = 1'b0;
    if (ar_hs)        ar_full_nx = 1'b1;
    else if (rd_term) ar_full_nx = 1'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      last_wr   <= 1'b1;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_o_q   <= '0;
      sel_q     <= '0;
    end else begin
      aw_full   <= aw_full_nx;
      w_full    <= w_full_nx;
      ar_full   <= ar_full_nx;
      awready_q <= !aw_full_nx;
      wready_q  <= !w_full_nx;
      arready_q <= !ar_full_nx;

      if (aw_hs) aw_addr_q <= s_axi.s_awaddr;
      if (w_hs) begin
        w_data_q <= s_axi.s_wdata;
        w_strb_q <= s_axi.s_wstrb;
      end
      if (ar_hs) ar_addr_q <= s_axi.s_araddr;

      case (state)
        IDLE: begin
          // On contention the type not served last goes first.
          if (read_req && (!write_req || last_wr)) begin
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= ar_addr_q;
            sel_q   <= '1;
            dat_o_q <= '0;
            last_wr <= 1'b0;
            state   <= WB_RD;
          end else if (write_req) begin
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= aw_addr_q;
            sel_q   <= w_strb_q;
            dat_o_q <= w_data_q;
            last_wr <= 1'b1;
            state   <= WB_WR;
          end
        end
        WB_WR: begin
          if (term) begin
            cyc_q    <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= term_resp;
            state    <= B_RESP;
          end
        end
        WB_RD: begin
          if (term) begin
            cyc_q    <= 1'b0;
            rvalid_q <= 1'b1;
            rresp_q  <= term_resp;
            rdata_q  <= (wb.wb_ack_i && !wb.wb_err_i) ? wb.wb_dat_i : '0;
            state    <= R_RESP;
          end
        end
        B_RESP: begin
          if (s_axi.s_bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        R_RESP: begin
          if (s_axi.s_rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_axi.s_awready = awready_q;
  assign s_axi.s_wready  = wready_q;
  assign s_axi.s_arready = arready_q;
  assign s_axi.s_bvalid  = bvalid_q;
  assign s_axi.s_bresp   = bresp_q;
  assign s_axi.s_rvalid  = rvalid_q;
  assign s_axi.s_rresp   = rresp_q;
  assign s_axi.s_rdata   = rdata_q;

  // Classic mode only: stb is the same register as cyc.
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_o_q;
  assign wb.wb_sel_o = sel_q;

endmodule

// File: tb/tb_axi4_lite_to_wb_bridge.sv
// Self-checking bench for axi4_lite_to_wb_bridge (TIMEOUT=8): directed cases plus random traffic.
// Latency: expectations from the transaction rules (2 + wait states, 1 + TIMEOUT on timeout).
// Backpressure: bench drives AXI master and a Wishbone slave with configurable wait/err/hang.
module tb_axi4_lite_to_wb_bridge;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_axi ();
  wb_if       #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_wb ();

  axi4_lite_to_wb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .s_axi    (bus_axi),
    .wb       (bus_wb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- Wishbone slave model ----------------
  int          slv_mode = 0;   // 0 ack, 1 err, 2 ack+err, 3 never respond
  int          slv_wait = 0;
  int          wait_cnt = 0;
  logic        late_ack = 1'b0;
  logic [31:0] slv_mem [64];
  logic [31:0] ref_mem [64];

  always_comb begin
    bus_wb.wb_ack_i = late_ack;
    bus_wb.wb_err_i = 1'b0;
    bus_wb.wb_dat_i = '0;
    if (bus_wb.wb_cyc_o && bus_wb.wb_stb_o && wait_cnt == slv_wait) begin
      if (slv_mode == 0 || slv_mode == 2) bus_wb.wb_ack_i = 1'b1;
      if (slv_mode == 1 || slv_mode == 2) bus_wb.wb_err_i = 1'b1;
      bus_wb.wb_dat_i = slv_mem[bus_wb.wb_adr_o[7:2]];
    end
  end

  always @(posedge clk) begin
    if (bus_wb.wb_cyc_o && !(bus_wb.wb_ack_i || bus_wb.wb_err_i)) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus_wb.wb_cyc_o && bus_wb.wb_we_o && bus_wb.wb_ack_i && !bus_wb.wb_err_i)
      for (int b = 0; b < 4; b++)
        if (bus_wb.wb_sel_o[b]) slv_mem[bus_wb.wb_adr_o[7:2]][8*b +: 8] <= bus_wb.wb_dat_o[8*b +: 8];
  end

  // ---------------- Wishbone monitor ----------------
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          len;
  } wbrec_t;

  wbrec_t wbq[$];
  wbrec_t cur;
  logic   prev_cyc = 1'b0;
  int     stb_bad = 0;
  int     stable_bad = 0;
  int     edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (bus_wb.wb_cyc_o !== bus_wb.wb_stb_o) stb_bad++;
    if (bus_wb.wb_cyc_o && !prev_cyc) begin
      cur.we = bus_wb.wb_we_o; cur.adr = bus_wb.wb_adr_o;
      cur.sel = bus_wb.wb_sel_o; cur.dat = bus_wb.wb_dat_o; cur.len = 1;
    end else if (bus_wb.wb_cyc_o) begin
      cur.len++;
      if (cur.we !== bus_wb.wb_we_o || cur.adr !== bus_wb.wb_adr_o ||
          cur.sel !== bus_wb.wb_sel_o || cur.dat !== bus_wb.wb_dat_o) stable_bad++;
    end else if (prev_cyc) begin
      wbq.push_back(cur);
    end
    prev_cyc = bus_wb.wb_cyc_o;
  end

  // ---------------- AXI master tasks (entered #1 after a rising edge) ----------------
  int hold_bad = 0;

  task automatic send_aw(input logic [31:0] a, output int hs);
    int n;
    n = 0;
    bus_axi.s_awaddr = a; bus_axi.s_awvalid = 1'b1;
    @(negedge clk);
    while (bus_axi.s_awready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("aw_ready_wait", 0, 1);
    @(posedge clk); #1;
    bus_axi.s_awvalid = 1'b0; hs = edge_cnt;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
    int n;
    n = 0;
    bus_axi.s_wdata = d; bus_axi.s_wstrb = s; bus_axi.s_wvalid = 1'b1;
    @(negedge clk);
    while (bus_axi.s_wready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("w_ready_wait", 0, 1);
    @(posedge clk); #1;
    bus_axi.s_wvalid = 1'b0; hs = edge_cnt;
  endtask

  task automatic send_ar(input logic [31:0] a, output int hs);
    int n;
    n = 0;
    bus_axi.s_araddr = a; bus_axi.s_arvalid = 1'b1;
    @(negedge clk);
    while (bus_axi.s_arready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ar_ready_wait", 0, 1);
    @(posedge clk); #1;
    bus_axi.s_arvalid = 1'b0; hs = edge_cnt;
  endtask

  task automatic get_b(input int hold, output logic [1:0] resp, output int ve);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_axi.s_bvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin chk("b_valid_wait", 0, 1); resp = 2'b11; ve = 0; return; end
    ve = edge_cnt; resp = bus_axi.s_bresp;
    repeat (hold) begin
      @(negedge clk);
      if (bus_axi.s_bvalid !== 1'b1 || bus_axi.s_bresp !== resp || bus_wb.wb_cyc_o !== 1'b0) hold_bad++;
    end
    bus_axi.s_bready = 1'b1;
    @(posedge clk); #1;
    bus_axi.s_bready = 1'b0;
  endtask

  task automatic get_r(input int hold, output logic [31:0] data, output logic [1:0] resp, output int ve);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_axi.s_rvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin chk("r_valid_wait", 0, 1); data = '0; resp = 2'b11; ve = 0; return; end
    ve = edge_cnt; resp = bus_axi.s_rresp; data = bus_axi.s_rdata;
    repeat (hold) begin
      @(negedge clk);
      if (bus_axi.s_rvalid !== 1'b1 || bus_axi.s_rresp !== resp ||
          bus_axi.s_rdata !== data || bus_wb.wb_cyc_o !== 1'b0) hold_bad++;
    end
    bus_axi.s_rready = 1'b1;
    @(posedge clk); #1;
    bus_axi.s_rready = 1'b0;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W. early counts cyc seen while one half waits.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold,
                           output logic [1:0] resp, output int lat, output int early);
    int e1, e2, ve, ee;
    ee = 0;
    fork
      begin
        if (lead > 0) repeat (lead) begin @(negedge clk); if (bus_wb.wb_cyc_o) ee++; @(posedge clk); #1; end
        send_aw(a, e1);
      end
      begin
        if (lead < 0) repeat (-lead) begin @(negedge clk); if (bus_wb.wb_cyc_o) ee++; @(posedge clk); #1; end
        send_w(d, s, e2);
      end
    join
    get_b(hold, resp, ve);
    lat = ve - ((e1 > e2) ? e1 : e2);
    early = ee;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int e1, ve;
    send_ar(a, e1);
    get_r(hold, data, resp, ve);
    lat = ve - e1;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input int len);
    wbrec_t r;
    chk({tag, "_wb_count"}, wbq.size(), 1);
    if (wbq.size() == 0) return;
    r = wbq.pop_front();
    chk({tag, "_wb_we"},  r.we,  we);
    chk({tag, "_wb_adr"}, r.adr, adr);
    chk({tag, "_wb_sel"}, r.sel, sel);
    chk({tag, "_wb_dat"}, r.dat, dat);
    if (len > 0) chk({tag, "_wb_len"}, r.len, len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int lat, early, n, hs;
    bus_axi.s_awvalid = 0; bus_axi.s_awaddr = 0; bus_axi.s_wvalid = 0; bus_axi.s_wdata = 0;
    bus_axi.s_wstrb = 0; bus_axi.s_bready = 0; bus_axi.s_arvalid = 0; bus_axi.s_araddr = 0;
    bus_axi.s_rready = 0;
    for (int i = 0; i < 64; i++) begin slv_mem[i] = $urandom; ref_mem[i] = slv_mem[i]; end

    // Reset state
    #22;
    chk("rst_wb_outputs", |{bus_wb.wb_cyc_o, bus_wb.wb_stb_o, bus_wb.wb_we_o, bus_wb.wb_adr_o,
                            bus_wb.wb_sel_o, bus_wb.wb_dat_o}, 0);
    chk("rst_axi_outputs", |{bus_axi.s_awready, bus_axi.s_wready, bus_axi.s_arready, bus_axi.s_bvalid,
                             bus_axi.s_bresp, bus_axi.s_rvalid, bus_axi.s_rresp, bus_axi.s_rdata}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {bus_axi.s_awready, bus_axi.s_wready, bus_axi.s_arready}, 3'b111);
    @(posedge clk); #1;

    // Arbitration: AR and AW+W together, twice -> read, write, read, write
    slv_mode = 0; slv_wait = 0;
    bus_axi.s_bready = 1'b1; bus_axi.s_rready = 1'b1;
    fork
      begin send_ar(32'h10, hs); send_ar(32'h30, hs); end
      begin send_aw(32'h20, hs); send_aw(32'h38, hs); end
      begin send_w(32'hA5A5_0001, 4'hF, hs); send_w(32'hA5A5_0002, 4'hF, hs); end
    join
    n = 0;
    while (wbq.size() < 4 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus_axi.s_bready = 1'b0; bus_axi.s_rready = 1'b0;
    ref_mem[8] = 32'hA5A5_0001; ref_mem[14] = 32'hA5A5_0002;
    chk("arb_count", wbq.size(), 4);
    if (wbq.size() == 4) begin
      chk("arb_order_we", {wbq[0].we, wbq[1].we, wbq[2].we, wbq[3].we}, 4'b0101);
      chk("arb_order_adr", {wbq[0].adr[7:0], wbq[1].adr[7:0], wbq[2].adr[7:0], wbq[3].adr[7:0]},
          32'h10_20_30_38);
    end
    wbq.delete();

    // Zero-wait write, AW and W in the same cycle
    axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, lat, early);
    ref_mem[16] = 32'hDEAD_BEEF;
    chk("w0_bresp", resp, 2'b00);
    chk("w0_latency", lat, 2);
    chk_wb("w0", 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF, 1);

    // Read with 3 wait states, rready held off 5 cycles
    slv_mem[17] = 32'h1234_5678; ref_mem[17] = 32'h1234_5678;
    slv_wait = 3; hold_bad = 0;
    axi_read(32'h44, 5, data, resp, lat);
    chk("r1_rdata", data, 32'h1234_5678);
    chk("r1_rresp", resp, 2'b00);
    chk("r1_latency", lat, 5);
    chk("r1_hold_stable", hold_bad, 0);
    chk_wb("r1", 1'b0, 32'h44, 4'hF, 32'h0, 4);

    // W four cycles before AW, partial strobe, slave gives ack+err
    slv_wait = 0; slv_mode = 2;
    axi_write(32'h48, 32'h0BAD_F00D, 4'h6, 4, 0, resp, lat, early);
    chk("w2_no_early_cycle", early, 0);
    chk("w2_bresp", resp, 2'b10);
    chk_wb("w2", 1'b1, 32'h48, 4'h6, 32'h0BAD_F00D, 1);

    // Timeout on a read; late ack during the response is ignored
    slv_mode = 3;
    send_ar(32'h4C, hs);
    n = 0;
    @(negedge clk);
    while (bus_axi.s_rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("tmo_latency", edge_cnt - hs, TMO + 1);
    @(posedge clk); #1; late_ack = 1'b1;
    @(posedge clk); #1; late_ack = 1'b0;
    hold_bad = 0;
    get_r(1, data, resp, lat);
    chk("tmo_rresp", resp, 2'b10);
    chk("tmo_rdata", data, 32'h0);
    chk("tmo_hold_stable", hold_bad, 0);
    chk_wb("tmo", 1'b0, 32'h4C, 4'hF, 32'h0, TMO);
    slv_mode = 0;
    axi_read(32'h40, 0, data, resp, lat);
    chk("post_tmo_rdata", data, ref_mem[16]);
    chk("post_tmo_rresp", resp, 2'b00);
    chk_wb("post_tmo", 1'b0, 32'h40, 4'hF, 32'h0, 1);

    // Reset while a read cycle is on the bus
    slv_mode = 3;
    send_ar(32'h80, hs);
    n = 0;
    while (bus_wb.wb_cyc_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    chk("midrst_wb_outputs", |{bus_wb.wb_cyc_o, bus_wb.wb_stb_o, bus_wb.wb_we_o, bus_wb.wb_adr_o,
                               bus_wb.wb_sel_o, bus_wb.wb_dat_o}, 0);
    chk("midrst_axi_outputs", |{bus_axi.s_awready, bus_axi.s_wready, bus_axi.s_arready,
                                bus_axi.s_bvalid, bus_axi.s_rvalid, bus_axi.s_rdata}, 0);
    slv_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", {bus_axi.s_awready, bus_axi.s_wready, bus_axi.s_arready}, 3'b111);
    n = 0;
    repeat (6) begin @(negedge clk); if (bus_axi.s_rvalid !== 1'b0 || bus_wb.wb_cyc_o !== 1'b0) n++; end
    chk("midrst_no_stale", n, 0);
    wbq.delete();
    @(posedge clk); #1;

    // Random traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      int idx, m, w, hold, lead, elat, wr;
      logic [31:0] a, d, e;
      logic [3:0]  s;
      idx = $urandom % 64; a = idx << 2;
      m = $urandom % 10;
      slv_mode = (m < 6) ? 0 : (m < 8) ? 1 : (m == 8) ? 2 : 3;
      slv_wait = $urandom % 4;
      w = (slv_mode == 3) ? TMO : slv_wait + 1;
      elat = (slv_mode == 3) ? TMO + 1 : slv_wait + 2;
      hold = $urandom % 3;
      wr = $urandom % 2;
      if (wr == 1) begin
        d = $urandom; s = 4'($urandom % 16); lead = int'($urandom % 7) - 3;
        axi_write(a, d, s, lead, hold, resp, lat, early);
        chk("rnd_bresp", resp, (slv_mode == 0) ? 2'b00 : 2'b10);
        chk("rnd_wlat", lat, elat);
        chk("rnd_early", early, 0);
        chk_wb("rnd_w", 1'b1, a, s, d, w);
        if (slv_mode == 0)
          for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        e = (slv_mode == 0) ? ref_mem[idx] : 32'h0;
        axi_read(a, hold, data, resp, lat);
        chk("rnd_rresp", resp, (slv_mode == 0) ? 2'b00 : 2'b10);
        chk("rnd_rdata", data, e);
        chk("rnd_rlat", lat, elat);
        chk_wb("rnd_r", 1'b0, a, 4'hF, 32'h0, w);
      end
    end

    chk("stb_equals_cyc", stb_bad, 0);
    chk("wb_outputs_stable", stable_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
